// File: rtl/kulisch_accum_sequencer.sv
// kulisch_accum_sequencer
// Sequences one Kulisch fixed-point accumulator through a dot-product
// reduction. Pre-aligned signed addends arrive on a valid/ready stream and are
// summed exactly. The addend flagged last moves the result to a valid/ready
// output port. After the result handshake the accumulator clears for the next
// reduction.
//
// Ports
//   clock      system clock, rising edge
//   resetn     asynchronous active-low reset
//   clear      synchronous abort, highest priority
//   in_valid   addend valid
//   in_ready   sequencer can accept an addend
//   in_data    two's-complement addend aligned to the accumulator binary point
//   in_isInf   addend is +/-inf or NaR
//   in_last    final addend of the reduction
//   out_valid  result available
//   out_ready  consumer accepts the result
//   out_data   {isInf, isOverflow, overflowSign, acc}
//   out_count  addends accepted in this reduction (saturating)
//
// state  | meaning
// ACCUM  | accepting addends; in_ready = 1
// OUTPUT | result held on out_data/out_count until out_ready
module kulisch_accum_sequencer #(
  parameter int ACC_NON_FRAC = 8,
  parameter int ACC_FRAC     = 8,
  parameter int COUNT_BITS   = 16,
  localparam int ACC_BITS    = 1 + ACC_NON_FRAC + ACC_FRAC,
  localparam int STRUCT_BITS = 3 + ACC_BITS
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ACC_BITS-1:0]    in_data,
  input  logic                   in_isInf,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [STRUCT_BITS-1:0] out_data,
  output logic [COUNT_BITS-1:0]  out_count
);

  typedef enum logic {ACCUM = 1'b0, OUTPUT = 1'b1} state_t;

  state_t state, state_nxt;

  logic [ACC_BITS-1:0]   acc;
  logic                  is_inf;
  logic                  is_ovf;
  logic                  ovf_sign;
  logic [COUNT_BITS-1:0] count;

  logic [ACC_BITS-1:0]   sum;
  logic                  ovf;
  logic                  accept;
  logic                  drain;

  localparam logic [COUNT_BITS-1:0] COUNT_ONE = {{(COUNT_BITS-1){1'b0}}, 1'b1};

  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  // Signed overflow: operands agree in sign but the wrapped sum does not.
  assign sum = acc + in_data;
  assign ovf = (acc[ACC_BITS-1] == in_data[ACC_BITS-1]) &&
               (sum[ACC_BITS-1] != acc[ACC_BITS-1]);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= ACCUM;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = ACCUM;
    end else begin
      case (state)
        ACCUM:   if (accept && in_last) state_nxt = OUTPUT;
        OUTPUT:  if (drain)             state_nxt = ACCUM;
        default: state_nxt = ACCUM;
      endcase
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACCUM:   in_ready  = 1'b1;
      OUTPUT:  out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      acc      <= '0;
      is_inf   <= 1'b0;
      is_ovf   <= 1'b0;
      ovf_sign <= 1'b0;
      count    <= '0;
    end else if (clear || drain) begin
      acc      <= '0;
      is_inf   <= 1'b0;
      is_ovf   <= 1'b0;
      ovf_sign <= 1'b0;
      count    <= '0;
    end else if (accept) begin
      // Once a flag is raised the accumulator is frozen for this reduction.
      if (!(is_inf || is_ovf)) begin
        if (in_isInf) begin
          is_inf <= 1'b1;
        end else if (ovf) begin
          is_ovf   <= 1'b1;
          ovf_sign <= in_data[ACC_BITS-1];
        end else begin
          acc <= sum;
        end
      end
      if (count != '1) count <= count + COUNT_ONE;
    end
  end

  assign out_data  = {is_inf, is_ovf, ovf_sign, acc};
  assign out_count = count;

endmodule

// File: tb/tb_kulisch_accum_sequencer.sv
// Self-checking bench for kulisch_accum_sequencer, 8-bit accumulator
// (3 integer bits, 4 fraction bits) and a 3-bit saturating counter.
module tb_kulisch_accum_sequencer;

  localparam int NF = 3;
  localparam int FR = 4;
  localparam int CB = 3;
  localparam int AB = 1 + NF + FR;
  localparam int SB = 3 + AB;
  localparam int CMAX = (1 << CB) - 1;
  localparam int VMAX = (1 << (AB - 1)) - 1;
  localparam int VMIN = -(1 << (AB - 1));

  logic          clock = 1'b0;
  logic          resetn;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [AB-1:0] in_data;
  logic          in_isInf;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [SB-1:0] out_data;
  logic [CB-1:0] out_count;

  kulisch_accum_sequencer #(
    .ACC_NON_FRAC(NF), .ACC_FRAC(FR), .COUNT_BITS(CB)
  ) dut (
    .clock(clock), .resetn(resetn), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_isInf(in_isInf), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int fails  = 0;

  // Reference model: the accumulator as a plain integer value.
  int m_acc;
  bit m_inf, m_ovf, m_sign;
  int m_cnt;

  task automatic model_clear();
    m_acc = 0; m_inf = 0; m_ovf = 0; m_sign = 0; m_cnt = 0;
  endtask

  task automatic model_add(input logic [AB-1:0] d, input bit inf);
    int v;
    v = int'($signed(d));
    if (!(m_inf || m_ovf)) begin
      if (inf) m_inf = 1;
      else if (m_acc + v > VMAX || m_acc + v < VMIN) begin
        m_ovf = 1;
        m_sign = (v < 0);
      end else m_acc = m_acc + v;
    end
    m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
  endtask

  function automatic logic [SB-1:0] exp_struct();
    logic [31:0] a;
    a = m_acc;
    return {m_inf, m_ovf, m_sign, a[AB-1:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [AB-1:0] d, input bit inf, input bit last);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (n >= 20) chk("send_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = d; in_isInf = inf; in_last = last;
    @(posedge clock);
    model_add(d, inf);
    @(negedge clock);
    in_valid = 1'b0; in_isInf = 1'b0; in_last = 1'b0;
  endtask

  // Called at the negedge one cycle after the last accept.
  task automatic collect(input string tag, input int hold);
    logic [SB-1:0] e;
    e = exp_struct();
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"},  32'(out_data),  32'(e));
    chk({tag, "_count"}, 32'(out_count), 32'(m_cnt));
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      chk({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_hold_data"},  32'(out_data), 32'(e));
    end
    out_ready = 1'b1;
    @(posedge clock);
    model_clear();
    @(negedge clock);
    out_ready = 1'b0;
    chk({tag, "_post_ready"}, 32'(in_ready),  32'd1);
    chk({tag, "_post_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_post_data"},  32'(out_data),  32'd0);
  endtask

  initial begin
    logic [SB-1:0] held;
    int len;
    resetn = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
    in_isInf = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    model_clear();
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    chk("rst_ready", 32'(in_ready),  32'd1);
    chk("rst_count", 32'(out_count), 32'd0);

    // Basic sum
    send(8'h18, 0, 0); send(8'h08, 0, 0); send(8'hF0, 0, 1);
    chk("basic_acc_lit", 32'(out_data), 32'h010);
    collect("basic", 0);

    // Positive overflow, acc frozen
    send(8'h70, 0, 0); send(8'h20, 0, 0); send(8'h01, 0, 1);
    chk("povf_lit", 32'(out_data), 32'h270);
    collect("povf", 0);

    // Negative overflow
    send(8'h90, 0, 0); send(8'hE0, 0, 1);
    chk("novf_lit", 32'(out_data), 32'h390);
    collect("novf", 0);

    // Infinity
    send(8'h10, 0, 0); send(8'h00, 1, 0); send(8'h10, 0, 1);
    chk("inf_lit", 32'(out_data), 32'h410);
    collect("inf", 0);

    // Single-addend reduction
    send(8'hC3, 0, 1);
    chk("single_count", 32'(out_count), 32'd1);
    collect("single", 0);

    // Counter saturation: 9 addends, 3-bit counter
    for (int i = 0; i < 9; i++) send(8'h01, 0, i == 8);
    chk("sat_count_lit", 32'(out_count), 32'd7);
    collect("sat", 0);

    // Backpressure with producer holding a new addend
    send(8'h40, 0, 0); send(8'h11, 0, 1);
    held = out_data;
    chk("bp_data", 32'(held), 32'(exp_struct()));
    in_valid = 1'b1; in_data = 8'h22; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("bp_ready", 32'(in_ready), 32'd0);
      chk("bp_stable", 32'(out_data), 32'(held));
      chk("bp_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clock);
    model_clear();
    @(negedge clock);
    out_ready = 1'b0;
    chk("bp_post_ready", 32'(in_ready), 32'd1);
    @(posedge clock);
    model_add(8'h22, 0);
    @(negedge clock);
    in_valid = 1'b0;
    send(8'h01, 0, 1);
    chk("bp_next_lit", 32'(out_data), 32'h023);
    collect("bp_next", 0);

    // Clear together with a last-addend accept
    send(8'h10, 0, 0);
    in_valid = 1'b1; in_data = 8'h05; in_last = 1'b1; clear = 1'b1;
    @(posedge clock);
    model_clear();
    @(negedge clock);
    clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    chk("clr_valid", 32'(out_valid), 32'd0);
    chk("clr_data",  32'(out_data),  32'd0);
    chk("clr_count", 32'(out_count), 32'd0);
    chk("clr_ready", 32'(in_ready),  32'd1);
    @(negedge clock);
    chk("clr_valid2", 32'(out_valid), 32'd0);

    // Clear while a result is pending, simultaneous with out_ready
    send(8'h30, 0, 1);
    chk("clro_pending", 32'(out_valid), 32'd1);
    clear = 1'b1; out_ready = 1'b1;
    @(posedge clock);
    model_clear();
    @(negedge clock);
    clear = 1'b0; out_ready = 1'b0;
    chk("clro_valid", 32'(out_valid), 32'd0);
    chk("clro_data",  32'(out_data),  32'd0);

    // Asynchronous reset during OUTPUT
    send(8'h30, 0, 0); send(8'h01, 0, 1);
    chk("arst_pending", 32'(out_valid), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data",  32'(out_data),  32'd0);
    chk("arst_count", 32'(out_count), 32'd0);
    model_clear();
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    chk("arst_ready", 32'(in_ready), 32'd1);

    // Randomized reductions
    for (int r = 0; r < 16; r++) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) @(negedge clock);
        send(8'($urandom_range(0, 255)), ($urandom_range(0, 9) == 0), i == len - 1);
      end
      collect("rand", $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/kulisch_accum_sequencer.md
Name: kulisch_accum_sequencer

Overview:
Sequences one Kulisch fixed-point accumulator through a dot-product reduction. It accepts a valid/ready stream of pre-aligned signed addends, each carrying an optional infinity marker, and accumulates them exactly. On the addend flagged last it presents the final accumulator struct on a valid/ready output port, then clears itself for the next reduction. It sits between the product/alignment stage and the Kulisch-to-float normaliser.

Parameters:
ACC_NON_FRAC, 8, non-fractional magnitude bits of the accumulator; the sign bit is extra.
ACC_FRAC, 8, fractional bits of the accumulator.
COUNT_BITS, 16, width of the accepted-term counter.
Derived: ACC_BITS = 1 + ACC_NON_FRAC + ACC_FRAC.
Derived: STRUCT_BITS = 3 + ACC_BITS.

Ports:
clock  in  1  system clock; all state changes on the rising edge.
resetn  in  1  asynchronous active-low reset.
clear  in  1  synchronous abort; discards the reduction in progress.
in_valid  in  1  addend valid.
in_ready  out  1  sequencer can accept an addend.
in_data  in  ACC_BITS  two's-complement addend, already aligned to the accumulator binary point.
in_isInf  in  1  addend represents ±inf or NaR.
in_last  in  1  final addend of the reduction.
out_valid  out  1  result available.
out_ready  in  1  consumer accepts the result.
out_data  out  STRUCT_BITS  {isInf, isOverflow, overflowSign, acc[ACC_BITS-1:0]}, isInf at the MSB.
out_count  out  COUNT_BITS  number of addends accepted in this reduction, saturating.

Behaviour:
- Reset (resetn low, asynchronous): state = ACCUM, acc = 0, isInf = 0, isOverflow = 0, overflowSign = 0, count = 0, out_valid = 0. in_ready = 1 once reset is released.
- States:
  - ACCUM: in_ready = 1, out_valid = 0.
  - OUTPUT: in_ready = 0, out_valid = 1; out_data and out_count are held stable.
- An addend is accepted when in_valid && in_ready. On the following edge:
  - sum = acc + in_data, computed at ACC_BITS width with wrap.
  - ovf = (acc[MSB] == in_data[MSB]) && (sum[MSB] != acc[MSB]).
  - If isInf or isOverflow is already set, acc is frozen; no further arithmetic or flag updates.
  - Else if in_isInf: isInf <= 1 and acc is unchanged.
  - Else if ovf: isOverflow <= 1, overflowSign <= in_data[MSB] (1 means negative overflow), and acc is unchanged.
  - Else acc <= sum.
  - count <= count + 1, saturating at all-ones. Count increments even when acc is frozen.
  - If in_last, the next state is OUTPUT.
- Latency: out_valid rises exactly 1 cycle after the edge that accepted the last addend, and out_data includes that addend.
- OUTPUT exits on out_valid && out_ready. On that edge:
  - acc, all flags and count are cleared.
  - The state returns to ACCUM, and in_ready = 1 in the next cycle.
  - There is no bypass: at least one idle input cycle separates reductions.
- clear is synchronous and has priority over every other event, including a simultaneous accept or output handshake. It clears acc, flags and count, forces ACCUM, and drops out_valid on the next edge. A result pending in OUTPUT is discarded.
- in_valid while in_ready = 0 has no effect. The producer holds the addend until it is accepted.
- A reduction of a single addend with in_last = 1 is legal and yields count = 1.
- resetn asserted mid-reduction or mid-OUTPUT aborts immediately to the reset values, with no output produced.
- out_data and out_count are registered and driven directly from state registers.

Test Plan:
All scenarios use ACC_NON_FRAC = 3 and ACC_FRAC = 4, giving ACC_BITS = 8 (value = data/16).
- Basic sum: addends 0x18, 0x08, 0xF0 (last), with out_ready = 1 -> out_valid 1 cycle after the last accept, acc = 0x10, flags 000, count = 3, in_ready = 1 on the next cycle.
- Positive overflow: addends 0x70, 0x20, then 0x01 (last) -> isOverflow = 1, overflowSign = 0, acc frozen at 0x70, count = 3.
- Negative overflow: addends 0x90, 0xE0 (last) -> isOverflow = 1, overflowSign = 1, acc = 0x90, count = 2.
- Infinity: addends 0x10, then in_isInf = 1, then 0x10 (last) -> isInf = 1, isOverflow = 0, acc = 0x10, count = 3.
- Backpressure: hold out_ready = 0 for 5 cycles with in_valid = 1 -> in_ready = 0 and out_data stable throughout. Raise out_ready -> handshake, then in_ready = 1 next cycle and the next reduction starts from acc = 0.
- Clear and reset:
  - clear asserted in the same cycle as an accept of 0x05 with in_last = 1 -> no output, acc = 0, count = 0.
  - resetn pulsed low mid-OUTPUT -> out_valid = 0 immediately (asynchronously).
